// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling driven by a
// realignable baud counter, and a one-entry valid/ready holding register.

// Baud counter: wraps every C clocks; 'half' realigns it to mid-bit.
module uart_baud #(
  parameter int unsigned CLOCK_HZ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic resetn,
  input  logic half,
  output logic tick
);
  localparam int unsigned C  = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned CW = (C > 2) ? $clog2(C) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(C - 1));

  // Free-running bit-period counter, reloaded to C/2 on a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   cnt_q <= '0;
    else if (half) cnt_q <= CW'(C / 2);
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end
endmodule

module uart_rx #(
  parameter int unsigned CLOCK_HZ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state_q;
  logic       rx_meta_q, rx_s_q, rx_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       fall;
  logic       half;
  logic       tick;

  assign fall = rx_q && !rx_s_q;
  assign half = (state_q == IDLE) && fall;
  assign busy = (state_q != IDLE);

  uart_baud #(
    .CLOCK_HZ (CLOCK_HZ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud (
    .clk   (clk),
    .resetn(resetn),
    .half  (half),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_q      <= rx_s_q;
    end
  end

  // Receive FSM, shift register, holding register and error pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Drain first; a delivery in the STOP branch below overrides it.
      if (valid && ready) valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) state_q <= START;
        end
        START: begin
          if (tick) begin
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            if (rx_s_q) begin
              if (!valid || ready) begin
                data  <= shift_q;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at C = 10 clocks per bit.
module tb_uart_rx;
  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLOCK_HZ (CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n (and until the next one) cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampling on the falling edge.
  int         fe_cnt = 0, fe_cyc = -1;
  int         ov_cnt = 0, ov_cyc = -1;
  int         acc_cnt = 0;
  logic [7:0] acc_data = '0;
  int         vrise_cyc = -1;
  logic [7:0] vrise_data = '0;
  int         brise_cnt = 0, brise_cyc = -1, bfall_cyc = -1;
  logic       prev_valid = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    prev_valid <= valid;
    prev_busy  <= busy;
    if (frame_err === 1'b1) begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
    if (overrun === 1'b1)   begin ov_cnt <= ov_cnt + 1; ov_cyc <= cyc; end
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_cnt  <= acc_cnt + 1;
      acc_data <= data;
    end
    if (valid === 1'b1 && prev_valid === 1'b0) begin
      vrise_cyc  <= cyc;
      vrise_data <= data;
    end
    if (busy === 1'b1 && prev_busy === 1'b0) begin
      brise_cnt <= brise_cnt + 1;
      brise_cyc <= cyc;
    end
    if (busy === 1'b0 && prev_busy === 1'b1) bfall_cyc <= cyc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, returning 1 time unit after the last one.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame. Called 1 unit after a rising edge; e0 is the first
  // edge that samples the start bit. Optionally raises ready for exactly the
  // edge e0+rdy_edge. Returns after edge e0+99 with rx left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_edge,
                            output int e0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    e0   = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      rx = bits[i/10];
      if (i == rdy_edge) ready = 1'b1;
      if (rdy_edge >= 0 && i == rdy_edge + 1) ready = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int e0, e0b, fe0, ov0, acc0, br0;

    resetn = 1'b0;
    rx     = 1'b1;
    ready  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    cycles(2);
    resetn = 1'b1;
    cycles(12);

    // 1: single byte 0xA5, ready held high
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
    send_frame(8'hA5, 1'b1, -1, e0);
    rx = 1'b1;
    cycles(5);
    check("t1_vrise_edge", vrise_cyc, e0 + 97);
    check("t1_vrise_data", vrise_data, 8'hA5);
    check("t1_acc_n", acc_cnt - acc0, 1);
    check("t1_acc_data", acc_data, 8'hA5);
    check("t1_busy_rise", brise_cyc, e0 + 2);
    check("t1_busy_fall", bfall_cyc, e0 + 97);
    check("t1_ferr_n", fe_cnt - fe0, 0);
    check("t1_ovr_n", ov_cnt - ov0, 0);
    check("t1_valid_drained", valid, 0);

    // 2: 3-cycle glitch, then real frame 0x3C
    fe0 = fe_cnt; acc0 = acc_cnt;
    e0 = cyc + 1;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(20);
    check("t2_busy_rise", brise_cyc, e0 + 2);
    check("t2_busy_fall", bfall_cyc, e0 + 7);
    check("t2_busy", busy, 0);
    check("t2_valid", valid, 0);
    check("t2_acc_n", acc_cnt - acc0, 0);
    check("t2_ferr_n", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, -1, e0);
    rx = 1'b1;
    cycles(5);
    check("t2_acc_n2", acc_cnt - acc0, 1);
    check("t2_acc_data", acc_data, 8'h3C);

    // 3: framing error, line held low, then frame 0x0F
    fe0 = fe_cnt; acc0 = acc_cnt;
    send_frame(8'h55, 1'b0, -1, e0);
    br0 = brise_cnt;
    cycles(30);
    check("t3_ferr_n", fe_cnt - fe0, 1);
    check("t3_ferr_edge", fe_cyc, e0 + 97);
    check("t3_valid", valid, 0);
    check("t3_acc_n", acc_cnt - acc0, 0);
    check("t3_break_busy", busy, 0);
    check("t3_break_nostart", brise_cnt - br0, 0);
    rx = 1'b1;
    cycles(10);
    send_frame(8'h0F, 1'b1, -1, e0);
    rx = 1'b1;
    cycles(5);
    check("t3_acc_n2", acc_cnt - acc0, 1);
    check("t3_acc_data", acc_data, 8'h0F);

    // 4: overrun with ready low, back-to-back 0x11 then 0x22
    ready = 1'b0;
    ov0 = ov_cnt; acc0 = acc_cnt;
    send_frame(8'h11, 1'b1, -1, e0);
    send_frame(8'h22, 1'b1, -1, e0b);
    rx = 1'b1;
    cycles(5);
    check("t4_valid", valid, 1);
    check("t4_data", data, 8'h11);
    check("t4_ovr_n", ov_cnt - ov0, 1);
    check("t4_ovr_edge", ov_cyc, e0b + 97);
    check("t4_acc_n", acc_cnt - acc0, 0);
    ready = 1'b1;
    @(negedge clk);
    check("t4_drain_valid", valid, 1);
    check("t4_drain_data", data, 8'h11);
    @(posedge clk);
    #1;
    check("t4_cleared", valid, 0);
    check("t4_acc_data", acc_data, 8'h11);
    ready = 1'b0;
    cycles(5);

    // 5: ready raised exactly at the edge 0x22 completes
    send_frame(8'h11, 1'b1, -1, e0);
    rx = 1'b1;
    cycles(3);
    check("t5_hold_data", data, 8'h11);
    ov0 = ov_cnt; acc0 = acc_cnt;
    send_frame(8'h22, 1'b1, 97, e0);
    rx = 1'b1;
    cycles(3);
    check("t5_valid", valid, 1);
    check("t5_data", data, 8'h22);
    check("t5_ovr_n", ov_cnt - ov0, 0);
    check("t5_acc_n", acc_cnt - acc0, 1);
    check("t5_acc_data", acc_data, 8'h11);

    // 6: reset during data bit 4 of 0xFF, then frame 0x81
    rx = 1'b0;
    cycles(10);
    rx = 1'b1;
    cycles(45);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_valid", valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_data", data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_ovr", overrun, 0);
    ready = 1'b1;
    cycles(3);
    resetn = 1'b1;
    cycles(20);
    check("t6_idle_busy", busy, 0);
    acc0 = acc_cnt;
    send_frame(8'h81, 1'b1, -1, e0);
    rx = 1'b1;
    cycles(5);
    check("t6_vrise_edge", vrise_cyc, e0 + 97);
    check("t6_acc_n", acc_cnt - acc0, 1);
    check("t6_acc_data", acc_data, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver controller for 8N1 serial input. It sequences an internal `uart_baud` instance: it realigns the baud counter on each start-bit edge with `half`, then samples the line on each `tick` at mid-bit. The received byte is handed to the core through a one-entry valid/ready holding register. It sits between the `rx` pad and the memory-mapped UART register block, alongside the transmitter.

## Interface

- `CLOCK_HZ`, 50000000, core clock frequency in Hz; passed to `uart_baud`.
- `BAUD_RATE`, 115200, line rate; passed to `uart_baud`.
- C = CLOCK_HZ / BAUD_RATE (integer division) is the number of clocks per bit. C >= 4 is required; the design is unsupported below that.

Ports:

- `clk` input 1: single clock domain, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `data` output 8: received byte; valid while `valid`=1.
- `valid` output 1: holding register is full.
- `ready` input 1: consumer accepts `data` when `valid && ready` at a rising edge.
- `busy` output 1: receiver FSM is not IDLE.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `overrun` output 1: one-cycle pulse; a byte completed while the holding register was full and not being drained.

## Operation

- **Synchronizer.** `rx` passes through two flops to give `rx_s`, then one more flop to give `rx_q`. All three reset to 1. `fall` = `rx_q && !rx_s`.
- **Baud control.**
  - `uart_baud.half` = (state==IDLE && `fall`), combinational, one cycle.
  - `uart_baud.resetn` is tied to `resetn`.
  - The baud counter free-runs in IDLE, and ticks are ignored there.
- **FSM.**
  - IDLE: on `fall`, go to START.
  - START: on `tick`, if `rx_s`==0 go to DATA with bit index 0; otherwise it is a glitch or false start, so go to IDLE with no error.
  - DATA: on `tick`, shift right with `rx_s` into bit 7 (LSB first). When bit index==7, go to STOP; otherwise increment the index. The index is 3 bits.
  - STOP: on `tick`, go to IDLE in both cases.
    - `rx_s`==1: deliver the byte.
    - `rx_s`==0: pulse `frame_err` on the next cycle and discard the byte.
- **Line held low.** Because a new start needs `fall`, a line held low (break) does not retrigger. Reception restarts only after the line returns high and then falls.
- **Delivery into the holding register**, evaluated at the edge that follows the stop tick:
  - `valid`==0: load `data`, set `valid`=1.
  - `valid`==1 and `ready`==1: load the new byte, keep `valid`=1.
  - `valid`==1 and `ready`==0: keep the old byte, pulse `overrun` for one cycle, and drop the new byte.
- **Drain.** `valid && ready` with no delivery in the same cycle clears `valid` on the next edge.
- **Busy.** `busy` = (state != IDLE), registered state.
- **Reset.** Reset in mid-frame returns to IDLE immediately and loses the partial byte. Reset values: `valid`=0, `data`=0, `busy`=0, `frame_err`=0, `overrun`=0, shift register 0, FSM IDLE.

## Timing

- **Start of frame.** Let edge 0 be the first rising edge at which the `rx` pin is sampled low.
  - `rx_s` falls after edge 1, and `half` is high in the cycle after edge 1.
  - The baud count equals C/2 after edge 2.
  - The start-bit tick is high in the cycle ending at edge 2+(C−1−C/2)+1 = 2+C−C/2. The FSM leaves START at that edge.
- **Bit sampling.** Data bit k is sampled at edge 2+C−C/2+(k+1)·C. The stop bit is sampled at 2+C−C/2+9C.
- **Delivery.** `valid` rises at that stop-sample edge + 0 (registered in the same edge as the STOP→IDLE transition). For C=10 this is edge 97.
- **Error pulses.** `frame_err` and `overrun` are asserted for exactly the one cycle following the stop-sample edge.
- **Back-to-back frames.** A new start edge may occur immediately after the stop bit. IDLE is re-entered at mid-stop-bit, so the half-bit of remaining stop time is sufficient to catch the next start edge.
- **Consumer throughput.** `ready` may be held high permanently, giving zero-cycle drain throughput.

## Test plan

Use CLOCK_HZ=1000000 and BAUD_RATE=100000 (C=10) throughout.

1. **Single byte.** Drive 0xA5 as 8N1 with `ready`=1, with the pin low sampled at edge 0 → `valid` rises at edge 97, `data`=0xA5, `busy` high from edge 2 through edge 97, no error pulses.
2. **False start.** A 3-cycle low glitch on an idle line → FSM goes START→IDLE at the start tick; no `valid`, no `frame_err`; the next real frame 0x3C is received correctly.
3. **Framing error.** Frame 0x55 with the stop bit driven low → one-cycle `frame_err`, `valid` stays 0. With the line then held low for 30 cycles → no new frame. Line high then frame 0x0F → received.
4. **Overrun.** With `ready`=0, send 0x11 then 0x22 back-to-back → `valid`=1 holding 0x11, `overrun` pulses at the second stop sample. Raise `ready` → `data`=0x11 drained and `valid` clears the next cycle.
5. **Simultaneous drain and delivery.** With `valid`=1 (0x11) and `ready` asserted exactly in the cycle 0x22 completes → `data`=0x22, `valid` stays 1, no `overrun`.
6. **Reset mid-frame.** Assert `resetn` low during data bit 4 of 0xFF → all outputs 0 asynchronously. Release, then send 0x81 → received as 0x81.
